// File: rtl/parity_stream_checker.sv
// parity_stream_checker: deserialises DATA_W-bit frames followed by one parity bit,
// flags parity errors per frame and keeps a saturating error count.
module parity_stream_checker #(
   parameter int DATA_W    = 4,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 odd_mode,
   input  logic                 in_valid,
   input  logic                 in_bit,
   input  logic                 frame_abort,
   input  logic                 clear_cnt,
   output logic                 busy,
   output logic                 out_valid,
   output logic [DATA_W-1:0]    data_out,
   output logic                 pec,
   output logic [ERR_CNT_W-1:0] err_cnt
);
   localparam int IDX_W = $clog2(DATA_W + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
   state_t               state_q;
   logic [IDX_W-1:0]     idx_q;
   logic                 acc_q;
   logic                 mode_q;
   logic [DATA_W-1:0]    shreg_q;
   logic                 out_valid_q;
   logic [DATA_W-1:0]    data_q;
   logic                 pec_q;
   logic [ERR_CNT_W-1:0] cnt_q;
   logic                 par_err_d;
   // Mode bit inverted equals total XOR exactly when the count of ones has the wrong parity.
   assign par_err_d = (acc_q ^ in_bit) == ~mode_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_q       <= 1'b0;
         mode_q      <= 1'b0;
         shreg_q     <= '0;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         pec_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= 1'b0;
         if (clear_cnt) cnt_q <= '0;
         if (frame_abort && state_q != IDLE) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= 1'b0;
         end else if (in_valid) begin
            case (state_q)
               IDLE: begin
                  mode_q  <= odd_mode;
                  shreg_q <= DATA_W'(in_bit);
                  acc_q   <= in_bit;
                  idx_q   <= IDX_W'(1);
                  state_q <= (DATA_W == 1) ? PARITY : DATA;
               end
               DATA: begin
                  shreg_q <= (shreg_q << 1) | DATA_W'(in_bit);
                  acc_q   <= acc_q ^ in_bit;
                  idx_q   <= idx_q + IDX_W'(1);
                  state_q <= (idx_q == IDX_W'(DATA_W - 1)) ? PARITY : DATA;
               end
               PARITY: begin
                  out_valid_q <= 1'b1;
                  data_q      <= shreg_q;
                  pec_q       <= par_err_d;
                  idx_q       <= '0;
                  acc_q       <= 1'b0;
                  state_q     <= IDLE;
                  if (par_err_d && !clear_cnt && cnt_q != '1) cnt_q <= cnt_q + ERR_CNT_W'(1);
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   assign busy      = state_q != IDLE;
   assign out_valid = out_valid_q;
   assign data_out  = data_q;
   assign pec       = pec_q;
   assign err_cnt   = cnt_q;
endmodule

// File: doc/parity_stream_checker.md
PARITY_STREAM_CHECKER -- requirements
Module: parity_stream_checker

Interface
REQ-001 Parameter DATA_W, default 4: number of data bits per frame, legal range 1..32.
REQ-002 Parameter ERR_CNT_W, default 8: width of the parity error counter, legal range 2..16.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port odd_mode, input, 1: 1 selects odd parity, 0 selects even parity; sampled at frame start.
REQ-006 Port in_valid, input, 1: in_bit is valid this cycle.
REQ-007 Port in_bit, input, 1: serial frame bit; each frame is DATA_W data bits (first bit first) followed by 1 parity bit.
REQ-008 Port frame_abort, input, 1: discards the partial frame in progress.
REQ-009 Port clear_cnt, input, 1: clears err_cnt.
REQ-010 Port busy, output, 1: a frame is in progress (state not IDLE).
REQ-011 Port out_valid, output, 1: one-cycle pulse marking a completed frame.
REQ-012 Port data_out, output, DATA_W: data bits of the last completed frame; the first received bit is at the MSB.
REQ-013 Port pec, output, 1: parity error flag of the last completed frame.
REQ-014 Port err_cnt, output, ERR_CNT_W: saturating count of frames with pec=1.

Function
REQ-015 The FSM shall have three states: IDLE, DATA and PARITY; a cycle with in_valid=0 shall not change the state, bit index or accumulator.
REQ-016 In IDLE, in_valid=1 shall:
- latch odd_mode as frame mode;
- shift in_bit in as the first data bit and start the running XOR;
- move to DATA, or to PARITY if DATA_W=1.
REQ-017 In DATA, each in_valid=1 shall shift in one data bit and update the XOR; after the DATA_W-th data bit is accepted, the state shall move to PARITY.
REQ-018 In PARITY, in_valid=1 shall accept the parity bit and return to IDLE, and on the next edge:
- out_valid=1;
- data_out = collected bits;
- pec = (XOR of data bits and parity bit) equal to the latched mode bit inverted; i.e. in odd mode, error if the total count of ones is even, and in even mode, error if it is odd.
REQ-019 Result latency shall be exactly 1 cycle after the parity bit is accepted; a new frame may start on the cycle immediately after the parity bit (back-to-back frames with no bubble).
REQ-020 out_valid shall be high for exactly one cycle per frame; data_out and pec shall hold their values until the next completed frame.
REQ-021 err_cnt shall increment on the same edge that pec=1 is registered, and shall saturate at 2^ERR_CNT_W-1.
REQ-022 If clear_cnt=1, err_cnt shall become 0 on the next edge; clear_cnt shall take priority over a simultaneous increment.
REQ-023 frame_abort=1 shall return the FSM to IDLE and clear the bit index and XOR on the next edge.
- It overrides a simultaneous in_valid.
- No out_valid is produced for the aborted frame, and data_out, pec and err_cnt are unchanged.
- frame_abort=1 in IDLE has no effect.
REQ-024 Changing odd_mode mid-frame shall not affect the frame in progress.
REQ-025 in_bit shall be ignored whenever in_valid=0.

Reset
REQ-026 When rst=1 on a clock edge, the block shall set:
- state = IDLE, bit index and XOR = 0;
- busy = 0, out_valid = 0, data_out = 0, pec = 0, err_cnt = 0.
REQ-027 rst shall override frame_abort, clear_cnt and in_valid; a frame interrupted by rst shall produce no output.

Verification
REQ-028 The bench shall cover these scenarios with DATA_W=4, ERR_CNT_W=8 unless stated otherwise:
- Reset: apply rst for 2 cycles mid-frame -> all outputs 0; the next parity bit produces no out_valid.
- Odd mode, bits 0,1,0,0 then parity 0 -> one cycle later: out_valid=1, data_out=4'b0100, pec=0, err_cnt=0.
- Odd mode, bits 0,0,0,0 parity 0 -> pec=1, err_cnt=1; then, back-to-back, even mode 1,1,1,1 parity 0 -> pec=0, data_out=4'b1111; then 1,1,1,1 parity 1 -> pec=1, err_cnt=2.
- Gaps and abort: in_valid=0 gaps between each bit give the same result as a gapless frame; frame_abort after 2 data bits, then a full frame 1,0,0,0 parity 0 (odd mode) -> a single out_valid, data_out=4'b1000, pec=0.
- Saturation with ERR_CNT_W=2: 4 error frames -> err_cnt=3; clear_cnt coincident with a 5th error -> err_cnt=0.
- Mode change mid-frame: odd_mode toggled during the data bits of an odd frame 0,0,0,1 parity 0 -> pec=0.
